// File: rtl/mem_initiator.sv
// Initiator side of the core memory port: one load, store or atomic RMW in flight,
// sequenced as IDLE -> READ -> WRITE -> RESP with a bounded wait-state timeout.
module mem_initiator #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_w,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_atomic,
    input  logic [DATA_W-1:0] mem_data_r,
    input  logic              mem_wait
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic              in_mem_phase;

    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (req_op == OP_STORE) ? WRITE : READ;
                end
            end
            READ: begin
                if (!mem_wait) begin
                    old_d   = mem_data_r;
                    state_d = (op_q == OP_LOAD) ? RESP : WRITE;
                end else if (cnt_q == WAIT_LIM) begin
                    // Timeout skips WRITE so an abandoned atomic never modifies memory.
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Request payload and captured read data carry no reset; outputs are gated by state.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        old_q   <= old_d;
    end

    assign in_mem_phase = (state_q == READ) || (state_q == WRITE);

    assign req_ready  = ready_q;
    assign busy       = (state_q != IDLE);
    assign mem_read   = (state_q == READ);
    assign mem_write  = (state_q == WRITE);
    assign mem_atomic = in_mem_phase && op_q[1];
    assign mem_addr   = in_mem_phase ? addr_q : '0;
    assign mem_data_w = (state_q != WRITE) ? '0 :
                        (op_q == OP_ADD)   ? wrap_add(old_q, wdata_q) : wdata_q;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = ((state_q == RESP) && !err_q && (op_q != OP_STORE)) ? old_q : '0;

endmodule
